// File: rtl/fifo_pkg.sv
// Shared constants and lane helpers for the sync_fifo consumer blocks.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_RATIO = 4;

  // Bit offset of lane k inside a packed word built from width-bit entries.
  function automatic int unsigned lane_offset(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_acc.sv
// Lane-indexed accumulator: collects entries little-endian into one wide word
// and exposes the word as it will look after this cycle's capture.
module packer_acc
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RATIO = DEF_RATIO,
  parameter int CNT_W = $clog2(RATIO + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   capture,
  input  logic [WIDTH-1:0]       cap_data,
  input  logic                   clear,
  output logic [CNT_W-1:0]       acc_cnt,
  output logic [WIDTH*RATIO-1:0] acc_word
);

  localparam int WORD_W = WIDTH * RATIO;

  logic [WORD_W-1:0] acc_data;

  // Merge the entry being captured into lane acc_cnt.
  always_comb begin
    // NOTE: acc_word gets a full default before the conditional lane write, so no latch is inferred.
    acc_word = acc_data;
    if (capture) begin
      for (int i = 0; i < RATIO; i++) begin
        if (acc_cnt == CNT_W'(i)) begin
          acc_word[lane_offset(i, WIDTH) +: WIDTH] = cap_data;
        end
      end
    end
  end

  // Accumulator storage: clear wins over capture because the merged word has
  // already been handed to the output register on that edge.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      // NOTE: the data lanes are cleared, not just the count, because a flushed
      // partial word relies on the unused upper lanes already being zero.
      acc_data <= '0;
      acc_cnt  <= '0;
    end else if (capture) begin
      // NOTE: non-blocking assignments keep every flop reading pre-edge values.
      acc_data <= acc_word;
      acc_cnt  <= acc_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops entries from a sync_fifo read port and packs RATIO of them into one
// little-endian word on a valid/ready port; flush emits a zero-padded partial.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RATIO = DEF_RATIO,
  parameter int CNT_W = $clog2(RATIO + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_data,
  output logic                   rd_en,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*RATIO-1:0] out_data,
  output logic [CNT_W-1:0]       out_cnt,
  output logic                   busy
);

  localparam int WORD_W = WIDTH * RATIO;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RATIO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);
  localparam logic [CNT_W:0]   OCC_FULL = (CNT_W + 1)'(RATIO);

  logic [CNT_W-1:0]  acc_cnt;
  logic [WORD_W-1:0] acc_word;
  logic [CNT_W:0]    occ;
  logic              inflight;
  logic              flush_pend;
  logic              out_can_load;
  logic              full_load;
  logic              flush_load;
  logic              load_word;

  packer_acc #(
    .WIDTH (WIDTH),
    .RATIO (RATIO),
    .CNT_W (CNT_W)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .capture  (inflight),
    .cap_data (fifo_data),
    .clear    (load_word),
    .acc_cnt  (acc_cnt),
    .acc_word (acc_word)
  );

  // Pop and load decisions from registered state; occ counts the entry in flight.
  always_comb begin
    out_can_load = !out_valid || out_ready;
    occ          = {1'b0, acc_cnt} + {{CNT_W{1'b0}}, inflight};
    full_load    = out_can_load && (occ == OCC_FULL);
    flush_load   = flush_pend && !inflight && (acc_cnt != '0) &&
                   (acc_cnt < CNT_FULL) && out_can_load;
    load_word    = full_load || flush_load;
    // The second term lets the pop for the next word overlap the capture that
    // completes this one, which is what sustains one pop per cycle.
    rd_en        = !fifo_empty && !flush_pend &&
                   ((occ < OCC_FULL) ||
                    (inflight && (acc_cnt == CNT_LAST) && out_can_load));
    busy         = (acc_cnt != '0) || inflight || flush_pend;
  end

  // Pop tracking: a pop issued this cycle returns data to capture next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
    end
  end

  // Flush request: held until the accumulator is empty or its partial is emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pend <= 1'b0;
    end else if (flush_pend) begin
      if (!inflight && ((acc_cnt == '0) || flush_load)) begin
        flush_pend <= 1'b0;
      end
    end else if (flush) begin
      flush_pend <= 1'b1;
    end
  end

  // Output register: loads a full or flushed word, otherwise holds until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
    end else if (load_word) begin
      out_valid <= 1'b1;
      out_data  <= acc_word;
      out_cnt   <= full_load ? CNT_FULL : acc_cnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: behavioural sync_fifo read port, word scoreboard
// filled at push time and drained by an output monitor.
module tb_fifo_rd_packer;

  localparam int WIDTH  = 8;
  localparam int RATIO  = 4;
  localparam int CNT_W  = 3;
  localparam int WORD_W = WIDTH * RATIO;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
  } word_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fifo_empty = 1'b1;
  logic [WIDTH-1:0]  fifo_data = '0;
  logic              rd_en;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WORD_W-1:0] out_data;
  logic [CNT_W-1:0]  out_cnt;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int pushes = 0;
  int words  = 0;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] pend_q[$];
  word_t            exp_q[$];

  logic              stall_prev = 1'b0;
  logic [WORD_W-1:0] prev_data;
  logic [CNT_W-1:0]  prev_cnt;

  fifo_rd_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .rd_en      (rd_en),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_cnt    (out_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // sync_fifo read-port model: data appears the cycle after rd_en is sampled.
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      fifo_empty <= 1'b1;
    end else if (rd_en) begin
      checks++;
      if (fifo_q.size() == 0) begin
        errors++;
        $display("FAIL rd_en_while_empty: rd_en=1 fifo_empty=%0b, required no pop", fifo_empty);
      end else begin
        fifo_data <= fifo_q.pop_front();
        pops++;
      end
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Output monitor: transfers compared against the scoreboard, stalls checked for stability.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      word_t e;
      checks++;
      words++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got data=%h cnt=%0d, required no word", out_data, out_cnt);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data || out_cnt !== e.cnt) begin
          errors++;
          $display("FAIL word: got data=%h cnt=%0d, required data=%h cnt=%0d",
                   out_data, out_cnt, e.data, e.cnt);
        end
      end
    end
    if (!rst && out_valid && !out_ready) begin
      if (stall_prev) begin
        checks++;
        if (out_data !== prev_data || out_cnt !== prev_cnt) begin
          errors++;
          $display("FAIL stall_stable: got data=%h cnt=%0d, required data=%h cnt=%0d",
                   out_data, out_cnt, prev_data, prev_cnt);
        end
      end
      stall_prev = 1'b1;
      prev_data  = out_data;
      prev_cnt   = out_cnt;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic raw_push(input logic [WIDTH-1:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
    pushes++;
  endtask

  // Push one entry and record the word it will complete, little-endian.
  task automatic push_byte(input logic [WIDTH-1:0] b);
    word_t w;
    raw_push(b);
    pend_q.push_back(b);
    if (pend_q.size() == RATIO) begin
      w.data = '0;
      for (int i = 0; i < RATIO; i++) w.data[i*WIDTH +: WIDTH] = pend_q[i];
      w.cnt = CNT_W'(RATIO);
      exp_q.push_back(w);
      pend_q.delete();
    end
  endtask

  task automatic do_flush();
    word_t w;
    if (pend_q.size() != 0) begin
      w.data = '0;
      for (int i = 0; i < pend_q.size(); i++) w.data[i*WIDTH +: WIDTH] = pend_q[i];
      w.cnt = CNT_W'(pend_q.size());
      exp_q.push_back(w);
      pend_q.delete();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d words outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0b, required %0b", name, got, req);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check_bit({name, "_rd_en"}, rd_en, 1'b0);
    check_bit({name, "_out_valid"}, out_valid, 1'b0);
    check_bit({name, "_busy"}, busy, 1'b0);
    checks++;
    if (out_data !== '0 || out_cnt !== '0) begin
      errors++;
      $display("FAIL %s_out_word: got data=%h cnt=%0d, required 0/0", name, out_data, out_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int highs = 0;
    int rises = 0;
    logic prev = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_byte(WIDTH'(8'h11 * i));
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (rd_en) highs++;
      if (rd_en && !prev) rises++;
      prev = rd_en;
    end
    tick();
    checks++;
    if (highs != 8 || rises != 1) begin
      errors++;
      $display("FAIL basic_rd_en_run: got %0d high cycles in %0d runs, required 8 in 1", highs, rises);
    end
    wait_drain(30, "basic");
  endtask

  task automatic test_backpressure();
    int pops0;
    int words0;
    out_ready = 1'b0;
    pops0  = pops;
    words0 = words;
    for (int i = 0; i < 12; i++) push_byte(WIDTH'(8'h30 + i));
    repeat (20) tick();
    checks++;
    if (pops - pops0 != 8) begin
      errors++;
      $display("FAIL bp_pops: got %0d pops, required 8", pops - pops0);
    end
    check_bit("bp_out_valid", out_valid, 1'b1);
    checks++;
    if (words != words0) begin
      errors++;
      $display("FAIL bp_no_transfer: got %0d transfers, required 0", words - words0);
    end
    out_ready = 1'b1;
    wait_drain(60, "bp");
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    push_byte(8'hA1);
    push_byte(8'hB2);
    push_byte(8'hC3);
    repeat (6) tick();
    check_bit("flush_busy_before", busy, 1'b1);
    do_flush();
    wait_drain(20, "flush");
    check_bit("flush_busy_after", busy, 1'b0);
  endtask

  task automatic test_flush_empty();
    logic seen = 1'b0;
    out_ready = 1'b1;
    check_bit("flush_empty_idle", busy, 1'b0);
    do_flush();
    check_bit("flush_empty_pend", busy, 1'b1);
    tick();
    check_bit("flush_empty_clear", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check_bit("flush_empty_no_valid", seen, 1'b0);
  endtask

  task automatic test_reset_mid();
    int base = pops;
    int n = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) raw_push(WIDTH'(8'hE0 + i));
    while (pops < base + 3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pops < base + 3) begin
      errors++;
      $display("FAIL mid_reset_reach: got %0d pops, required 3", pops - base);
    end
    rst = 1'b1;
    tick();
    check_outputs_zero("mid_reset");
    rst = 1'b0;
    pend_q.delete();
    tick();
    for (int i = 0; i < 4; i++) push_byte(WIDTH'(8'h5A + i));
    wait_drain(30, "mid_reset");
  endtask

  task automatic test_random();
    int pops0 = pops;
    int push0 = pushes;
    int n = 0;
    for (int c = 0; c < 1000; c++) begin
      if ($urandom_range(0, 1) == 1 && fifo_q.size() < 16) push_byte(WIDTH'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    out_ready = 1'b1;
    while (fifo_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    repeat (3) tick();
    do_flush();
    wait_drain(100, "random");
    checks++;
    if (pops - pops0 != pushes - push0) begin
      errors++;
      $display("FAIL random_counts: got %0d pops, required %0d", pops - pops0, pushes - push0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_flush_empty();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
